// File: rtl/seq_equality_checker.sv
// Framed, masked word-stream equality checker with a valid/ready input.
// Reports per-word results, the mismatch count, the first mismatch index and a frame-level equal flag.
module seq_equality_checker #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic [WIDTH-1:0]               mask,
    output logic                           busy,
    output logic                           word_eq_valid,
    output logic                           word_eq,
    output logic                           done,
    output logic                           frame_eq,
    output logic [$clog2(FRAME_LEN+1)-1:0] mismatch_cnt,
    output logic [$clog2(FRAME_LEN)-1:0]   first_mismatch_idx
);
    // state  | meaning
    // S_IDLE | waiting for start; the previous frame's results hold
    // S_RUN  | accepting words, in_ready high
    // S_DONE | one-cycle done pulse carrying the final frame results
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] MAX_CNT  = CW'(FRAME_LEN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] first_q, first_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          weq_valid_q, weq_valid_d;
    logic          weq_q, weq_d;
    logic          done_q, done_d;
    logic          feq_q, feq_d;
    logic          word_match;

    assign word_match = (((a ^ b) & mask) == '0);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        weq_valid_d = 1'b0;
        weq_d       = weq_q;
        done_d      = 1'b0;
        feq_d       = feq_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_RUN;
                    idx_d      = '0;
                    cnt_d      = '0;
                    first_d    = '0;
                    weq_d      = 1'b0;
                    feq_d      = 1'b0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                // Data inputs are only looked at on an accept, so X on idle cycles cannot leak.
                if (in_valid) begin
                    weq_valid_d = 1'b1;
                    weq_d       = word_match;
                    if (!word_match) begin
                        if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
                        if (cnt_q == '0)      first_d = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d    = S_DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                        feq_d      = (cnt_d == '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            weq_valid_q <= 1'b0;
            weq_q       <= 1'b0;
            done_q      <= 1'b0;
            feq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            weq_valid_q <= weq_valid_d;
            weq_q       <= weq_d;
            done_q      <= done_d;
            feq_q       <= feq_d;
        end
    end

    assign in_ready           = in_ready_q;
    assign busy               = busy_q;
    assign word_eq_valid      = weq_valid_q;
    assign word_eq            = weq_q;
    assign done               = done_q;
    assign frame_eq           = feq_q;
    assign mismatch_cnt       = cnt_q;
    assign first_mismatch_idx = first_q;

endmodule

// File: tb/tb_seq_equality_checker.sv
// Directed bench for seq_equality_checker (WIDTH=8, FRAME_LEN=4).
// Observed outputs are packed as {busy,in_ready,word_eq_valid,word_eq,done,frame_eq,mismatch_cnt[2:0],first_idx[1:0]}.
module tb_seq_equality_checker;
    logic       clk = 1'b0;
    logic       rst, start, in_valid;
    logic [7:0] a, b, mask;
    logic       in_ready, busy, word_eq_valid, word_eq, done, frame_eq;
    logic [2:0] mismatch_cnt;
    logic [1:0] first_mismatch_idx;
    logic [10:0] obs, exp_v;
    int vectors = 0;
    int miscompares = 0;

    seq_equality_checker #(.WIDTH(8), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mask(mask), .busy(busy), .word_eq_valid(word_eq_valid),
        .word_eq(word_eq), .done(done), .frame_eq(frame_eq),
        .mismatch_cnt(mismatch_cnt), .first_mismatch_idx(first_mismatch_idx)
    );

    always #5 clk = ~clk;

    assign obs = {busy, in_ready, word_eq_valid, word_eq, done, frame_eq, mismatch_cnt, first_mismatch_idx};

    // Hand-computed frames: all-equal, and mismatch+mask with results 1,0,1,0.
    logic [7:0] eq_a   [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    logic [7:0] mm_a   [4] = '{8'h01, 8'h10, 8'h0F, 8'h80};
    logic [7:0] mm_b   [4] = '{8'h01, 8'h00, 8'h0E, 8'h00};
    logic [7:0] mm_m   [4] = '{8'hFF, 8'hFF, 8'hF0, 8'h80};
    logic       mm_eq  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] mm_cnt [4] = '{3'd0, 3'd1, 3'd1, 3'd2};
    logic [1:0] mm_fst [4] = '{2'd0, 2'd1, 2'd1, 2'd1};

    function automatic logic [10:0] ev(input logic bsy, input logic rdy, input logic wv, input logic we,
                                       input logic dn, input logic fe, input logic [2:0] cnt, input logic [1:0] fi);
        return {bsy, rdy, wv, we, dn, fe, cnt, fi};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [7:0] wa, input logic [7:0] wb, input logic [7:0] wm);
        in_valid = 1'b1; a = wa; b = wb; mask = wm;
        tick();
        in_valid = 1'b0; a = 'x; b = 'x; mask = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b1; a = 8'h12; b = 8'h34; mask = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (obs !== 11'd0) begin
                miscompares++; $display("FAIL reset_%0d: got %b want %b", i, obs, 11'd0);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 11'd0) begin
                miscompares++; $display("FAIL idle_ignores_valid_%0d: got %b want %b", i, obs, 11'd0);
            end
        end
        in_valid = 1'b0; a = 'x; b = 'x; mask = 'x;
    endtask

    task automatic test_all_equal();
        start = 1'b1; tick(); start = 1'b0;
        exp_v = ev(1, 1, 0, 0, 0, 0, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL eq_start: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 4; i++) begin
            drive_word(eq_a[i], eq_a[i], 8'hFF);
            exp_v = ev(1, i != 3, 1, 1, i == 3, i == 3, 3'd0, 2'd0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL eq_word_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        tick();
        exp_v = ev(0, 0, 0, 1, 0, 1, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL eq_idle_after: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_mismatch_mask();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_word(mm_a[i], mm_b[i], mm_m[i]);
            exp_v = ev(1, i != 3, 1, mm_eq[i], i == 3, 0, mm_cnt[i], mm_fst[i]);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL mm_word_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        tick();
        exp_v = ev(0, 0, 0, 0, 0, 0, 3'd2, 2'd1);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL mm_idle_after: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_stalls();
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_word(eq_a[i], eq_a[i], 8'hFF);
            exp_v = ev(1, i != 3, 1, 1, i == 3, i == 3, 3'd0, 2'd0);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL stall_word_%0d: got %b want %b", i, obs, exp_v);
            end
            if (i != 3) begin
                for (int s = 0; s < 3; s++) begin
                    tick();
                    exp_v = ev(1, 1, 0, 1, 0, 0, 3'd0, 2'd0);
                    vectors++;
                    if (obs !== exp_v) begin
                        miscompares++; $display("FAIL stall_gap_%0d_%0d: got %b want %b", i, s, obs, exp_v);
                    end
                end
            end
        end
        tick();
        exp_v = ev(0, 0, 0, 1, 0, 1, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL stall_idle_after: got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            drive_word(mm_a[i], mm_b[i], mm_m[i]);
            exp_v = ev(1, i != 3, 1, mm_eq[i], i == 3, 0, mm_cnt[i], mm_fst[i]);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++; $display("FAIL b2b_word_%0d: got %b want %b", i, obs, exp_v);
            end
        end
        tick();
        exp_v = ev(0, 0, 0, 0, 0, 0, 3'd2, 2'd1);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL b2b_idle_hold: got %b want %b", obs, exp_v);
        end
        tick();
        start = 1'b0;
        exp_v = ev(1, 1, 0, 0, 0, 0, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL b2b_second_start: got %b want %b", obs, exp_v);
        end
        for (int i = 0; i < 4; i++) drive_word(eq_a[i], eq_a[i], 8'h00);
        exp_v = ev(1, 0, 1, 1, 1, 1, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL b2b_second_done: got %b want %b", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_mid_frame_reset();
        start = 1'b1; tick(); start = 1'b0;
        drive_word(mm_a[0], mm_b[0], mm_m[0]);
        drive_word(mm_a[1], mm_b[1], mm_m[1]);
        exp_v = ev(1, 1, 1, 0, 0, 0, 3'd1, 2'd1);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL abort_pre_reset: got %b want %b", obs, exp_v);
        end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++; $display("FAIL abort_reset: got %b want %b", obs, 11'd0);
        end
        in_valid = 1'b1; a = 8'h01; b = 8'h02; mask = 8'hFF;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (obs !== 11'd0) begin
            miscompares++; $display("FAIL abort_no_done: got %b want %b", obs, 11'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) drive_word(eq_a[i], eq_a[i], 8'hFF);
        exp_v = ev(1, 0, 1, 1, 1, 1, 3'd0, 2'd0);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++; $display("FAIL abort_new_frame_done: got %b want %b", obs, exp_v);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; mask = '0;
        test_reset();
        test_all_equal();
        test_mismatch_mask();
        test_stalls();
        test_back_to_back();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
